// File: rtl/mul_sched_if.sv
// Bus bundle between the modular-arithmetic front end, mul_sched and the shared multiplier.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface mul_sched_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MUL_SIZE = 56
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*MUL_SIZE-1:0] req_a;
    logic [NUM_REQ*MUL_SIZE-1:0] req_b;

    logic                        mul_en;
    logic [MUL_SIZE-1:0]         mul_a;
    logic [MUL_SIZE-1:0]         mul_b;
    logic [2*MUL_SIZE-1:0]       mul_res;

    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [2*MUL_SIZE-1:0]       rsp_data;
    logic [IdW-1:0]              rsp_id;
    logic                        busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_res, rsp_ready,
        output req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_res, rsp_ready,
        input  req_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier among NUM_REQ requesters,
// returning each product with its requester index on a backpressured response port.
module mul_sched #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MUL_SIZE = 56,
    parameter int unsigned MUL_LAT  = 3
) (
    input logic        clk,
    input logic        rst_n,
    mul_sched_if.slave bus
);
    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [IdW-1:0]      last_q, last_d;
    logic [IdW-1:0]      rsp_id_q, rsp_id_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [MUL_SIZE-1:0] mul_a_q, mul_a_d;
    logic [MUL_SIZE-1:0] mul_b_q, mul_b_d;

    logic                gnt_found;
    logic [IdW-1:0]      gnt_idx;
    logic                arb_en;
    logic                hs;
    logic [NUM_REQ-1:0]  req_ready;

    // First valid requester searching upward from last+1, wrapping at NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            if (!gnt_found && bus.req_valid[IdW'((32'(last_q) + off) % NUM_REQ)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdW'((32'(last_q) + off) % NUM_REQ);
            end
        end
    end

    // Arbitration runs in IDLE, and in RESP only once the response is accepted.
    always_comb begin
        arb_en    = (state_q == StIdle) || ((state_q == StResp) && bus.rsp_ready);
        hs        = arb_en && gnt_found;
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rsp_id_d = rsp_id_q;
        cnt_d    = cnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;

        case (state_q)
            StIdle: begin
                if (hs) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = CntW'(MUL_LAT - 1);
                state_d = (MUL_LAT > 1) ? StWait : StResp;
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = hs ? StIssue : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (hs) begin
            last_d   = gnt_idx;
            rsp_id_d = gnt_idx;
            mul_a_d  = bus.req_a[gnt_idx*MUL_SIZE +: MUL_SIZE];
            mul_b_d  = bus.req_b[gnt_idx*MUL_SIZE +: MUL_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            last_q   <= IdW'(NUM_REQ - 1);
            rsp_id_q <= '0;
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            rsp_id_q <= rsp_id_d;
            cnt_q    <= cnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mul_en    = (state_q == StIssue);
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = (state_q == StResp);
    // mul_res is stable through RESP because mul_en is never raised there.
    assign bus.rsp_data  = (state_q == StResp) ? bus.mul_res : '0;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_mul_sched.sv
// Randomized bench for mul_sched: a timeline model of each transaction predicts every output
// each cycle, and directed scenarios pin the model with hand-computed values.
module tb_mul_sched;
    localparam int N       = 4;
    localparam int MS      = 56;
    localparam int MUL_LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mul_sched_if #(.NUM_REQ(N), .MUL_SIZE(MS)) bus ();

    mul_sched #(.NUM_REQ(N), .MUL_SIZE(MS), .MUL_LAT(MUL_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Multiplier stand-in: garbage while computing, product MUL_LAT cycles after mul_en.
    logic [2*MS-1:0] mp;
    int              mcnt;
    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt        <= 0;
            bus.mul_res <= '0;
        end else if (bus.mul_en) begin
            mp <= {{MS{1'b0}}, bus.mul_a} * {{MS{1'b0}}, bus.mul_b};
            if (MUL_LAT == 1) begin
                bus.mul_res <= {{MS{1'b0}}, bus.mul_a} * {{MS{1'b0}}, bus.mul_b};
            end else begin
                bus.mul_res <= (2*MS)'({$urandom(), $urandom(), $urandom(), $urandom()});
                mcnt        <= MUL_LAT - 1;
            end
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) bus.mul_res <= mp;
        end
    end

    // Model: m_age counts cycles since the last accepted handshake (0 = nothing in flight).
    int           m_age;
    int           m_last;
    int           m_id;
    logic [MS-1:0] m_a, m_b;
    bit           model_ok = 1'b0;
    logic [N-1:0] hs_vec = '0;
    int           gnt_log[$];
    int           gnt_cyc[$];

    always @(negedge clk) begin
        logic            arb;
        logic            found;
        int              g;
        logic [N-1:0]    er;
        logic [2*MS-1:0] prod;
        logic            exp_rv;

        arb   = (m_age == 0) || (m_age > MUL_LAT && bus.rsp_ready);
        found = 1'b0;
        g     = 0;
        for (int k = 1; k <= N; k++) begin
            if (!found && bus.req_valid[(m_last + k) % N]) begin
                found = 1'b1;
                g     = (m_last + k) % N;
            end
        end
        er = '0;
        if (arb && found) er[g] = 1'b1;
        prod   = {{MS{1'b0}}, m_a} * {{MS{1'b0}}, m_b};
        exp_rv = (m_age > MUL_LAT);

        if (model_ok) begin
            chk("req_ready", 128'(bus.req_ready), 128'(er));
            chk("mul_en",    128'(bus.mul_en),    128'(m_age == 1));
            chk("mul_a",     128'(bus.mul_a),     128'(m_a));
            chk("mul_b",     128'(bus.mul_b),     128'(m_b));
            chk("rsp_valid", 128'(bus.rsp_valid), 128'(exp_rv));
            chk("rsp_data",  128'(bus.rsp_data),  exp_rv ? 128'(prod) : 128'(0));
            chk("rsp_id",    128'(bus.rsp_id),    128'(m_id));
            chk("busy",      128'(bus.busy),      128'(m_age != 0));
        end

        hs_vec = bus.req_valid & bus.req_ready;
        for (int i = 0; i < N; i++) begin
            if (hs_vec[i]) begin
                gnt_log.push_back(i);
                gnt_cyc.push_back(cyc);
            end
        end

        if (!rst_n) begin
            model_ok = 1'b1;
            m_age    = 0;
            m_last   = N - 1;
            m_id     = 0;
            m_a      = '0;
            m_b      = '0;
        end else if (arb && found) begin
            m_last = g;
            m_id   = g;
            m_a    = bus.req_a[g*MS +: MS];
            m_b    = bus.req_b[g*MS +: MS];
            m_age  = 1;
        end else if (m_age > 0 && m_age <= MUL_LAT) begin
            m_age++;
        end else if (m_age > MUL_LAT && bus.rsp_ready) begin
            m_age = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [MS-1:0] rand_op();
        int unsigned r;
        r = $urandom_range(7);
        if (r == 0) return '1;
        if (r == 1) return '0;
        return MS'({$urandom(), $urandom()});
    endfunction

    // Requesters raise valid at random and hold it with stable operands until their handshake.
    task automatic run_random(input int cycles, input int pv, input int pr,
                              input logic [N-1:0] mask, input int prst);
        for (int c = 0; c < cycles; c++) begin
            step();
            rst_n = 1'b1;
            if (prst > 0 && $urandom_range(prst - 1) == 0) rst_n = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (hs_vec[i]) bus.req_valid[i] = 1'b0;
                if (!bus.req_valid[i] && mask[i] && $urandom_range(99) < pv) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_a[i*MS +: MS] = rand_op();
                    bus.req_b[i*MS +: MS] = rand_op();
                end
            end
            bus.rsp_ready = ($urandom_range(99) < pr);
        end
    endtask

    task automatic single(input int id, input logic [MS-1:0] a, input logic [MS-1:0] b,
                          input logic [2*MS-1:0] exp);
        step();
        bus.rsp_ready          = 1'b1;
        bus.req_valid          = '0;
        bus.req_valid[id]      = 1'b1;
        bus.req_a[id*MS +: MS] = a;
        bus.req_b[id*MS +: MS] = b;
        @(negedge clk);
        chk("single_grant", 128'(bus.req_ready), 128'(1) << id);
        for (int k = 1; k <= MUL_LAT + 2; k++) begin
            step();
            bus.req_valid = '0;
            @(negedge clk);
            chk("single_mul_en",    128'(bus.mul_en),    128'(k == 1));
            chk("single_busy",      128'(bus.busy),      128'(k <= MUL_LAT + 1));
            chk("single_rsp_valid", 128'(bus.rsp_valid), 128'(k == MUL_LAT + 1));
            if (k == MUL_LAT + 1) begin
                chk("single_rsp_data", 128'(bus.rsp_data), 128'(exp));
                chk("single_rsp_id",   128'(bus.rsp_id),   128'(id));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  exp_c[5];
        int  exp_d[4];
        bit  got;

        exp_c = '{0, 1, 2, 3, 0};
        exp_d = '{1, 3, 1, 3};
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values after the initial reset.
        @(negedge clk);
        chk("reset_busy",      128'(bus.busy),      128'(0));
        chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("reset_mul_a",     128'(bus.mul_a),     128'(0));

        single(0, 56'd3, 56'd5, 112'd15);
        single(0, '1, '1, 112'hFFFFFFFFFFFFFE00000000000001);

        // All requesters continuously valid: grants 0,1,2,3,0 every MUL_LAT+1 cycles.
        do_reset();
        gnt_log.delete();
        gnt_cyc.delete();
        run_random(24, 100, 100, 4'b1111, 0);
        chk("rr_all_count", 128'(gnt_log.size() >= 5), 128'(1));
        if (gnt_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_all_order", 128'(gnt_log[k]), 128'(exp_c[k]));
            for (int k = 1; k < 5; k++)
                chk("rr_all_spacing", 128'(gnt_cyc[k] - gnt_cyc[k-1]), 128'(MUL_LAT + 1));
        end

        // Only requesters 1 and 3 ever valid.
        do_reset();
        gnt_log.delete();
        gnt_cyc.delete();
        run_random(24, 100, 100, 4'b1010, 0);
        chk("sparse_count", 128'(gnt_log.size() >= 4), 128'(1));
        if (gnt_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("sparse_order", 128'(gnt_log[k]), 128'(exp_d[k]));
        end

        // Backpressure in RESP while requester 2 waits.
        do_reset();
        step();
        bus.rsp_ready        = 1'b0;
        bus.req_valid[0]     = 1'b1;
        bus.req_a[0*MS +: MS] = 56'd7;
        bus.req_b[0*MS +: MS] = 56'd9;
        @(negedge clk);
        step();
        bus.req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
            else step();
        end
        chk("bp_reach_resp", 128'(got), 128'(1));
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) begin
                bus.req_valid[2]      = 1'b1;
                bus.req_a[2*MS +: MS] = rand_op();
                bus.req_b[2*MS +: MS] = rand_op();
            end
            @(negedge clk);
            chk("bp_req_ready", 128'(bus.req_ready), 128'(0));
            chk("bp_mul_en",    128'(bus.mul_en),    128'(0));
            chk("bp_rsp_valid", 128'(bus.rsp_valid), 128'(1));
            chk("bp_rsp_data",  128'(bus.rsp_data),  128'(63));
            chk("bp_rsp_id",    128'(bus.rsp_id),    128'(0));
        end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 128'(bus.req_ready), 128'(4'b0100));
        step();
        bus.req_valid = '0;

        // Reset during WAIT discards the product; requester 0 wins afterwards.
        do_reset();
        step();
        bus.rsp_ready         = 1'b1;
        bus.req_valid[1]      = 1'b1;
        bus.req_a[1*MS +: MS] = rand_op();
        bus.req_b[1*MS +: MS] = rand_op();
        @(negedge clk);
        step();
        bus.req_valid = '0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 128'(bus.busy), 128'(1));
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy",      128'(bus.busy),      128'(0));
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_rsp_data",  128'(bus.rsp_data),  128'(0));
        chk("rst_rsp_id",    128'(bus.rsp_id),    128'(0));
        chk("rst_mul_a",     128'(bus.mul_a),     128'(0));
        chk("rst_mul_b",     128'(bus.mul_b),     128'(0));
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("rst_no_rsp", 128'(bus.rsp_valid), 128'(0));
        end
        step();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*MS +: MS] = rand_op();
            bus.req_b[i*MS +: MS] = rand_op();
        end
        bus.req_valid = '1;
        @(negedge clk);
        chk("rst_first_grant", 128'(bus.req_ready), 128'(4'b0001));

        // Long random run with backpressure and occasional resets.
        do_reset();
        run_random(3000, 40, 70, 4'b1111, 400);
        step();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
